// File: rtl/basic_gates_if.sv
// basic_gates_if: operand/result bundle for basic_gates.
//   master : drives in_valid, a, b; observes the registered gate results.
//   slave  : the gate bank itself.
// Signals:
//   in_valid, a, b          operand strobe and operands
//   and/or/not/nand/nor/xor/xnor_out  registered bitwise results (WIDTH)
//   eq_out                  registered a == b flag
//   out_valid               results belong to the pair captured on the last edge
//   notb_out                ~b, present only when BASIC_GATES_NOTB_EN is defined
interface basic_gates_if #(
  parameter int WIDTH = 1
);
  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] and_out;
  logic [WIDTH-1:0] or_out;
  logic [WIDTH-1:0] not_out;
  logic [WIDTH-1:0] nand_out;
  logic [WIDTH-1:0] nor_out;
  logic [WIDTH-1:0] xor_out;
  logic [WIDTH-1:0] xnor_out;
  logic             eq_out;
  logic             out_valid;
`ifdef BASIC_GATES_NOTB_EN
  logic [WIDTH-1:0] notb_out;
`endif

  modport master (
    output in_valid, a, b,
    input  and_out, or_out, not_out, nand_out, nor_out, xor_out, xnor_out,
`ifdef BASIC_GATES_NOTB_EN
    input  notb_out,
`endif
    input  eq_out, out_valid
  );

  modport slave (
    input  in_valid, a, b,
    output and_out, or_out, not_out, nand_out, nor_out, xor_out, xnor_out,
`ifdef BASIC_GATES_NOTB_EN
    output notb_out,
`endif
    output eq_out, out_valid
  );
endinterface

// File: rtl/basic_gates.sv
// basic_gates: registered bank of bitwise gates (AND, OR, NOT, NAND, NOR,
// XOR, XNOR) plus an equality flag. Operands captured on in_valid appear on
// all outputs one clock later together with out_valid.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset; clears every output (including the
//        inverting gates) and wins over in_valid
//   bus  basic_gates_if.slave operand/result bundle
// Optional: define BASIC_GATES_NOTB_EN to add bus.notb_out = ~b (registered,
// reset to 0, holds like the other results).

// One bit of the gate bank. Each bit is fully independent, so the bank is an
// array of these.
module basic_gates_lane (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic a,
  input  logic b,
  output logic and_q,
  output logic or_q,
  output logic not_q,
  output logic nand_q,
  output logic nor_q,
  output logic xor_q,
`ifdef BASIC_GATES_NOTB_EN
  output logic notb_q,
`endif
  output logic xnor_q
);
  // Operands are only looked at under en, so X on idle operands never
  // reaches the registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      and_q  <= 1'b0;
      or_q   <= 1'b0;
      not_q  <= 1'b0;
      nand_q <= 1'b0;
      nor_q  <= 1'b0;
      xor_q  <= 1'b0;
      xnor_q <= 1'b0;
`ifdef BASIC_GATES_NOTB_EN
      notb_q <= 1'b0;
`endif
    end else if (en) begin
      and_q  <= a & b;
      or_q   <= a | b;
      not_q  <= ~a;
      nand_q <= ~(a & b);
      nor_q  <= ~(a | b);
      xor_q  <= a ^ b;
      xnor_q <= ~(a ^ b);
`ifdef BASIC_GATES_NOTB_EN
      notb_q <= ~b;
`endif
    end
  end
endmodule

module basic_gates #(
  parameter int WIDTH = 1
) (
  input logic          clk,
  input logic          rst,
  basic_gates_if.slave bus
);
  localparam int STAGES = 1;

  // vld_pipe[0] is the live strobe; later taps are registered copies.
  logic [STAGES:0]  vld_pipe;
  logic [WIDTH-1:0] and_q;
  logic [WIDTH-1:0] or_q;
  logic [WIDTH-1:0] not_q;
  logic [WIDTH-1:0] nand_q;
  logic [WIDTH-1:0] nor_q;
  logic [WIDTH-1:0] xor_q;
  logic [WIDTH-1:0] xnor_q;
`ifdef BASIC_GATES_NOTB_EN
  logic [WIDTH-1:0] notb_q;
`endif
  logic             eq_q;

  assign vld_pipe[0] = bus.in_valid;

  always_ff @(posedge clk) begin
    if (rst) vld_pipe[STAGES:1] <= '0;
    else     vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    basic_gates_lane u_lane (
      .clk    (clk),
      .rst    (rst),
      .en     (vld_pipe[0]),
      .a      (bus.a[i]),
      .b      (bus.b[i]),
      .and_q  (and_q[i]),
      .or_q   (or_q[i]),
      .not_q  (not_q[i]),
      .nand_q (nand_q[i]),
      .nor_q  (nor_q[i]),
      .xor_q  (xor_q[i]),
`ifdef BASIC_GATES_NOTB_EN
      .notb_q (notb_q[i]),
`endif
      .xnor_q (xnor_q[i])
    );
  end

  // Equality spans all bits, so it lives outside the per-bit lanes. It is
  // registered alongside them so eq_out == &xnor_out whenever results are valid.
  always_ff @(posedge clk) begin
    if (rst)              eq_q <= 1'b0;
    else if (vld_pipe[0]) eq_q <= (bus.a == bus.b);
  end

  assign bus.and_out   = and_q;
  assign bus.or_out    = or_q;
  assign bus.not_out   = not_q;
  assign bus.nand_out  = nand_q;
  assign bus.nor_out   = nor_q;
  assign bus.xor_out   = xor_q;
  assign bus.xnor_out  = xnor_q;
`ifdef BASIC_GATES_NOTB_EN
  assign bus.notb_out  = notb_q;
`endif
  assign bus.eq_out    = eq_q;
  assign bus.out_valid = vld_pipe[STAGES];
endmodule

// File: tb/tb_basic_gates.sv
module tb_basic_gates;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   nvec = 0;
  int   nerr = 0;

  always #5 clk = ~clk;

  basic_gates_if #(.WIDTH(1)) bus1 ();
  basic_gates_if #(.WIDTH(8)) bus8 ();

  basic_gates #(.WIDTH(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));
  basic_gates #(.WIDTH(8)) u_dut8 (.clk(clk), .rst(rst), .bus(bus8));

  // Reference model: the last operand pair accepted, whether a reset has
  // happened since, and whether the previous edge accepted anything.
  logic [7:0] m_a = '0, m_b = '0;
  logic       m_zero = 1'b1, m_valid = 1'b0;

  // Result layout: {valid, eq, notb, xnor, xor, nor, nand, not, or, and}
  function automatic logic [65:0] pk(input logic v, e, input logic [7:0] an, o, nt,
                                     na, no, x, xn, nb);
    return {v, e, nb, xn, x, no, na, nt, o, an};
  endfunction

  function automatic logic [65:0] expect_vec(input int w);
    logic [7:0] mk, nb;
    mk = (w == 8) ? 8'hFF : 8'h01;
    if (m_zero) return '0;
`ifdef BASIC_GATES_NOTB_EN
    nb = ~m_b & mk;
`else
    nb = 8'h00;
`endif
    return pk(m_valid, ((m_a ^ m_b) & mk) == 8'h00, m_a & m_b & mk, (m_a | m_b) & mk,
              ~m_a & mk, ~(m_a & m_b) & mk, ~(m_a | m_b) & mk, (m_a ^ m_b) & mk,
              ~(m_a ^ m_b) & mk, nb);
  endfunction

  function automatic logic [65:0] actual1();
    logic [7:0] nb;
`ifdef BASIC_GATES_NOTB_EN
    nb = {7'b0, bus1.notb_out};
`else
    nb = 8'h00;
`endif
    return pk(bus1.out_valid, bus1.eq_out, {7'b0, bus1.and_out}, {7'b0, bus1.or_out},
              {7'b0, bus1.not_out}, {7'b0, bus1.nand_out}, {7'b0, bus1.nor_out},
              {7'b0, bus1.xor_out}, {7'b0, bus1.xnor_out}, nb);
  endfunction

  function automatic logic [65:0] actual8();
    logic [7:0] nb;
`ifdef BASIC_GATES_NOTB_EN
    nb = bus8.notb_out;
`else
    nb = 8'h00;
`endif
    return pk(bus8.out_valid, bus8.eq_out, bus8.and_out, bus8.or_out, bus8.not_out,
              bus8.nand_out, bus8.nor_out, bus8.xor_out, bus8.xnor_out, nb);
  endfunction

  // Apply one cycle of stimulus to both DUTs and advance the model.
  task automatic drive(input logic r, v, input logic [7:0] av, bv);
    @(negedge clk);
    rst = r;
    bus1.in_valid = v; bus1.a = av[0]; bus1.b = bv[0];
    bus8.in_valid = v; bus8.a = av;    bus8.b = bv;
    @(posedge clk);
    if (r) begin
      m_zero = 1'b1; m_valid = 1'b0;
    end else if (v) begin
      m_a = av; m_b = bv; m_zero = 1'b0; m_valid = 1'b1;
    end else begin
      m_valid = 1'b0;
    end
    #1;
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b0, 8'hA5, 8'h5A);
    drive(1'b1, 1'b1, 8'hFF, 8'h00);
    nvec++;
    if (actual1() !== 66'h0) begin
      nerr++; $display("FAIL reset_w1: got %h want 0", actual1());
    end
    nvec++;
    if (actual8() !== 66'h0) begin
      nerr++; $display("FAIL reset_w8: got %h want 0", actual8());
    end
  endtask

  task automatic test_w1_sweep();
    logic [1:0] ab;
    drive(1'b0, 1'b1, 8'h00, 8'h00);
    nvec++;
    if (actual1() !== {1'b1, 1'b1, 8'h00, 8'h01, 8'h00, 8'h01, 8'h01, 8'h01, 8'h00, 8'h00}) begin
      nerr++; $display("FAIL w1_ab00: got %h", actual1());
    end
    for (int i = 1; i < 4; i++) begin
      ab = 2'(i);
      drive(1'b0, 1'b1, {7'b0, ab[1]}, {7'b0, ab[0]});
      nvec++;
      if (actual1() !== expect_vec(1)) begin
        nerr++; $display("FAIL w1_ab%b: got %h want %h", ab, actual1(), expect_vec(1));
      end
    end
    // spec table row 11 spelled out directly
    nvec++;
    if ({bus1.and_out, bus1.or_out, bus1.not_out, bus1.nand_out, bus1.nor_out,
         bus1.xor_out, bus1.xnor_out, bus1.eq_out, bus1.out_valid} !== 9'b110000111) begin
      nerr++; $display("FAIL w1_ab11_lit: got %b want 110000111",
        {bus1.and_out, bus1.or_out, bus1.not_out, bus1.nand_out, bus1.nor_out,
         bus1.xor_out, bus1.xnor_out, bus1.eq_out, bus1.out_valid});
    end
  endtask

  task automatic test_w8_pattern();
    drive(1'b0, 1'b1, 8'hF0, 8'h3C);
    nvec++;
    if ({bus8.xnor_out, bus8.xor_out, bus8.nor_out, bus8.nand_out, bus8.not_out,
         bus8.or_out, bus8.and_out, bus8.eq_out, bus8.out_valid}
        !== {56'h33CC03CF0FFC30, 1'b0, 1'b1}) begin
      nerr++; $display("FAIL w8_f0_3c: got %h", actual8());
    end
    nvec++;
    if (actual8() !== expect_vec(8)) begin
      nerr++; $display("FAIL w8_f0_3c_model: got %h want %h", actual8(), expect_vec(8));
    end
  endtask

  task automatic test_hold_reset();
    logic [65:0] held1, held8;
    drive(1'b0, 1'b1, 8'hFF, 8'hFF);
    held1 = expect_vec(1); held8 = expect_vec(8);
    for (int i = 0; i < 3; i++) begin
      if (i == 2) drive(1'b0, 1'b0, 8'hxx, 8'hxx);
      else        drive(1'b0, 1'b0, 8'(i * 8'h5A), 8'(~i));
      nvec++;
      if (actual1() !== {1'b0, held1[64:0]}) begin
        nerr++; $display("FAIL hold_w1_%0d: got %h want %h", i, actual1(), {1'b0, held1[64:0]});
      end
      nvec++;
      if (actual8() !== {1'b0, held8[64:0]}) begin
        nerr++; $display("FAIL hold_w8_%0d: got %h want %h", i, actual8(), {1'b0, held8[64:0]});
      end
    end
    drive(1'b1, 1'b1, 8'h0F, 8'h0F);
    nvec++;
    if (actual8() !== 66'h0) begin
      nerr++; $display("FAIL rst_over_valid_w8: got %h want 0", actual8());
    end
    nvec++;
    if (actual1() !== 66'h0) begin
      nerr++; $display("FAIL rst_over_valid_w1: got %h want 0", actual1());
    end
  endtask

  task automatic test_back_to_back_random();
    logic r, v;
    for (int i = 0; i < 300; i++) begin
      r = ($urandom_range(0, 24) == 0);
      v = ($urandom_range(0, 3) != 0);
      drive(r, v, 8'($urandom), 8'($urandom));
      nvec++;
      if (actual1() !== expect_vec(1)) begin
        nerr++; $display("FAIL rand_w1_%0d: got %h want %h", i, actual1(), expect_vec(1));
      end
      nvec++;
      if (actual8() !== expect_vec(8)) begin
        nerr++; $display("FAIL rand_w8_%0d: got %h want %h", i, actual8(), expect_vec(8));
      end
      if (bus8.out_valid === 1'b1) begin
        nvec++;
        if (bus8.nand_out !== ~bus8.and_out || bus8.nor_out !== ~bus8.or_out ||
            bus8.xnor_out !== ~bus8.xor_out || bus8.eq_out !== &bus8.xnor_out) begin
          nerr++; $display("FAIL invariant_w8_%0d: got %h", i, actual8());
        end
      end
    end
  endtask

`ifdef BASIC_GATES_NOTB_EN
  task automatic test_notb();
    drive(1'b0, 1'b1, 8'h11, 8'h3C);
    nvec++;
    if (bus8.notb_out !== 8'hC3) begin
      nerr++; $display("FAIL notb_3c: got %h want c3", bus8.notb_out);
    end
    drive(1'b1, 1'b0, 8'h00, 8'h00);
    nvec++;
    if (bus8.notb_out !== 8'h00) begin
      nerr++; $display("FAIL notb_reset: got %h want 00", bus8.notb_out);
    end
  endtask
`endif

  initial begin
    bus1.in_valid = 1'b0; bus1.a = '0; bus1.b = '0;
    bus8.in_valid = 1'b0; bus8.a = '0; bus8.b = '0;
    test_reset();
    test_w1_sweep();
    test_w8_pattern();
    test_hold_reset();
    test_back_to_back_random();
`ifdef BASIC_GATES_NOTB_EN
    test_notb();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
